// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, the zero register and a register-match helper.
package hazard_ctrl_pkg;

   typedef logic [1:0] fwd_t;
   typedef logic [1:0] need_t;

   // Decode-stage branch operand selects
   localparam fwd_t FWD_RF  = 2'b00;
   localparam fwd_t FWD_M   = 2'b01;
   localparam fwd_t FWD_E   = 2'b10;

   // Execute-stage operand selects
   localparam fwd_t FWD_W   = 2'b01;
   localparam fwd_t FWD_MEM = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // $0 is hard-wired to zero, so it never produces a forward or a stall
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
      return (src != REG_ZERO) && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle. The pipeline (master) drives the
// stage register numbers and control bits; the hazard unit (slave) returns
// forward selects and stall/flush controls. All signals are level-valued
// within a cycle: there is no valid/ready pairing, every output is a pure
// response to the current cycle's inputs plus the internal stall counter,
// which is also exported as cnt for observation.
interface hazard_ctrl_if;
   logic [4:0] RsD;
   logic [4:0] RtD;
   logic [4:0] RsE;
   logic [4:0] RtE;
   logic [4:0] WriteRegE;
   logic [4:0] WriteRegM;
   logic [4:0] WriteRegW;
   logic       RegWriteE;
   logic       RegWriteM;
   logic       RegWriteW;
   logic       MemtoRegE;
   logic       MemtoRegM;
   logic       BranchD;
   logic       JumpD;
   logic       PCSrcD;

   logic [1:0] ForwardAD;
   logic [1:0] ForwardBD;
   logic [1:0] ForwardAE;
   logic [1:0] ForwardBE;
   logic       StallF;
   logic       StallD;
   logic       FlushD;
   logic       FlushE;
   logic [1:0] cnt;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, JumpD, PCSrcD,
      input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
             StallF, StallD, FlushD, FlushE, cnt
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, JumpD, PCSrcD,
      output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
             StallF, StallD, FlushD, FlushE, cnt
   );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Two-level priority forward select for one source operand. The "near"
// stage is the younger producer and wins over the "far" stage.
module hazard_ctrl_fwd_sel
   import hazard_ctrl_pkg::*;
#(
   parameter fwd_t SEL_NEAR = FWD_E,
   parameter fwd_t SEL_FAR  = FWD_M
) (
   input  logic [4:0] src,
   input  logic       near_en,
   input  logic [4:0] near_reg,
   input  logic       far_en,
   input  logic [4:0] far_reg,
   output fwd_t       sel
);

   // Pick the youngest producer writing this source register
   always_comb begin
      sel = FWD_RF;
      if (near_en && reg_match(src, near_reg)) begin
         sel = SEL_NEAR;
      end else if (far_en && reg_match(src, far_reg)) begin
         sel = SEL_FAR;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: decode and execute
// forward selects, load-use / load-to-branch stall sequencing, and
// branch/jump flush, plus a saturating count of stalled cycles.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   hazard_ctrl_if.slave           hif,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [STALL_CNT_W-1:0] SC_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   need_t      need;
   logic [1:0] stall_cnt;
   logic       stall;
   logic       dec_near_en;
   logic       dec_far_en;

   // A load's value is not an ALU result, so loads never feed decode forwarding
   assign dec_near_en = hif.RegWriteE && !hif.MemtoRegE;
   assign dec_far_en  = hif.RegWriteM && !hif.MemtoRegM;

   hazard_ctrl_fwd_sel #(.SEL_NEAR(FWD_E), .SEL_FAR(FWD_M)) u_fwd_ad (
      .src(hif.RsD), .near_en(dec_near_en), .near_reg(hif.WriteRegE),
      .far_en(dec_far_en), .far_reg(hif.WriteRegM), .sel(hif.ForwardAD)
   );

   hazard_ctrl_fwd_sel #(.SEL_NEAR(FWD_E), .SEL_FAR(FWD_M)) u_fwd_bd (
      .src(hif.RtD), .near_en(dec_near_en), .near_reg(hif.WriteRegE),
      .far_en(dec_far_en), .far_reg(hif.WriteRegM), .sel(hif.ForwardBD)
   );

   hazard_ctrl_fwd_sel #(.SEL_NEAR(FWD_MEM), .SEL_FAR(FWD_W)) u_fwd_ae (
      .src(hif.RsE), .near_en(hif.RegWriteM), .near_reg(hif.WriteRegM),
      .far_en(hif.RegWriteW), .far_reg(hif.WriteRegW), .sel(hif.ForwardAE)
   );

   hazard_ctrl_fwd_sel #(.SEL_NEAR(FWD_MEM), .SEL_FAR(FWD_W)) u_fwd_be (
      .src(hif.RtE), .near_en(hif.RegWriteM), .near_reg(hif.WriteRegM),
      .far_en(hif.RegWriteW), .far_reg(hif.WriteRegW), .sel(hif.ForwardBE)
   );

   // Number of stall cycles the current decode instruction requires
   always_comb begin
      need = 2'd0;
      if (hif.BranchD && hif.MemtoRegE &&
          (reg_match(hif.RsD, hif.WriteRegE) || reg_match(hif.RtD, hif.WriteRegE))) begin
         need = 2'd2;
      end else if (hif.MemtoRegE &&
                   (reg_match(hif.RsD, hif.RtE) || reg_match(hif.RtD, hif.RtE))) begin
         need = 2'd1;
      end else if (hif.BranchD && hif.MemtoRegM &&
                   (reg_match(hif.RsD, hif.WriteRegM) || reg_match(hif.RtD, hif.WriteRegM))) begin
         need = 2'd1;
      end
   end

   // The detection cycle stalls combinationally; the counter covers the rest.
   // Reset masks the stall so it drops at once even if a hazard is still visible.
   assign stall = !reset && ((stall_cnt != 2'd0) || (need != 2'd0));

   assign hif.StallF = stall;
   assign hif.StallD = stall;
   assign hif.FlushE = stall;
   // A taken branch held by a stall is flushed only once it is released
   assign hif.FlushD = !reset && (hif.PCSrcD || hif.JumpD) && !stall;
   assign hif.cnt    = stall_cnt;

   // Remaining counted stall cycles; new hazards are ignored while counting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 2'd0;
      end else if (stall_cnt != 2'd0) begin
         stall_cnt <= stall_cnt - 2'd1;
      end else if (need != 2'd0) begin
         stall_cnt <= need - 2'd1;
      end
   end

   // Saturating count of stalled cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + SC_ONE;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Generates the decode-stage branch-operand forward selects (`ForwardAD`/`ForwardBD`, which drive the decode forwarding muxes), the execute-stage forward selects, and the stall and flush controls. A registered stall counter sequences multi-cycle stalls for load-use and load-to-branch dependencies. A saturating stall-cycle counter is exposed for debug.

## Interface
Parameters:
- `STALL_CNT_W`, 16, width of the debug stall-cycle counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RsD`, `RtD`  in  5 each  source registers of the instruction in decode.
- `RsE`, `RtE`  in  5 each  source registers of the instruction in execute.
- `WriteRegE`, `WriteRegM`, `WriteRegW`  in  5 each  destination registers in EX/MEM/WB.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each  register-write enables per stage.
- `MemtoRegE`, `MemtoRegM`  in  1 each  the instruction in that stage is a load.
- `BranchD`  in  1  branch in decode.
- `JumpD`  in  1  jump in decode.
- `PCSrcD`  in  1  branch resolved taken in decode.
- `ForwardAD`, `ForwardBD`  out  2 each  decode operand select: 00 register file, 01 ALUOutM, 10 EX ALU result; 11 never driven.
- `ForwardAE`, `ForwardBE`  out  2 each  execute operand select: 00 register file, 01 ResultW, 10 ALUOutM.
- `StallF`, `StallD`  out  1 each  hold the PC and the IF/ID register.
- `FlushD`  out  1  clear the IF/ID register.
- `FlushE`  out  1  clear the ID/EX register (insert bubble).
- `stall_cycles`  out  `STALL_CNT_W`  saturating count of stalled cycles.

## Operation
- Register $0 is never a forward or stall match source.
- ForwardAD (and symmetrically ForwardBD with RtD), priority order:
  - 10 if `RegWriteE & !MemtoRegE & WriteRegE==RsD`.
  - else 01 if `RegWriteM & !MemtoRegM & WriteRegM==RsD`.
  - else 00.
- ForwardAE (and symmetrically ForwardBE with RtE):
  - 10 if `RegWriteM & WriteRegM==RsE`.
  - else 01 if `RegWriteW & WriteRegW==RsE`.
  - else 00.
- Hazard detection, `need`:
  - 2 if `BranchD & MemtoRegE & WriteRegE∈{RsD,RtD}`.
  - else 1 if `MemtoRegE & RtE∈{RsD,RtD}` (load-use).
  - else 1 if `BranchD & MemtoRegM & WriteRegM∈{RsD,RtD}`.
  - else 0.
- Stall counter `cnt` (2 bits, registered):
  - `cnt==0 & need>0`: stall asserted this cycle (combinational); `cnt <= need-1`.
  - `cnt>0`: stall asserted; `cnt <= cnt-1`; `need` is ignored.
- Stall asserted means `StallF = StallD = FlushE = 1`.
- `FlushD = (PCSrcD | JumpD) & !stall`. A taken branch waiting on a stall is not flushed until it resolves.
- `stall_cycles` increments by 1 in every stalled cycle and saturates at all-ones.
- Forward selects are pure combinational functions of current inputs. They are valid during stalls and are not masked.

## Timing
- Reset (asynchronous): `cnt=0`, `stall_cycles=0`. With all enables low, every output is 0.
- Forward, stall and flush outputs are combinational within the cycle. The only state is `cnt` and `stall_cycles`, both updated on the rising edge.
- Load-to-branch from EX: stall for 2 consecutive cycles (detection cycle plus 1 counted cycle). The branch then reads the load result through write-first register file access in WB.
- Load-use and load-in-MEM-to-branch: stall for 1 cycle; `cnt` stays 0.
- Reset asserted mid-stall: `cnt` and the stall outputs clear immediately. Release takes effect on the next edge.
- Simultaneous stall and `PCSrcD`: stall wins and `FlushD=0`.

## Structure
- Shared package/include `hazard_defs`: forward select encodings (`FWD_RF=2'b00`, `FWD_M=2'b01`, `FWD_E=2'b10`; execute-stage `FWD_W=2'b01`, `FWD_MEM=2'b10`) and `REG_ZERO=5'd0`.
- One natural sub-module: `fwd_sel`. It takes one source register plus the stage match terms and returns a 2-bit select. It is instantiated four times with stage-specific encodings.

## Test plan
- Reset mid-stall: start a 2-cycle load-to-branch stall, assert `reset` in the counted cycle -> Stall/Flush outputs drop to 0 immediately, `cnt=0`, `stall_cycles=0`.
- EX-to-branch forward: `BranchD=1, RsD=8, RegWriteE=1, MemtoRegE=0, WriteRegE=8` -> `ForwardAD=10`, no stall. Same with `WriteRegM=8` only -> `ForwardAD=01`.
- Load-use: `MemtoRegE=1, RtE=9, RtD=9, BranchD=0` -> exactly 1 cycle of `StallF=StallD=FlushE=1`; `stall_cycles` goes from 0 to 1.
- Load-to-branch: `BranchD=1, MemtoRegE=1, WriteRegE=10, RsD=10` -> stall for 2 cycles even after the inputs change; `PCSrcD=1` during the stall gives `FlushD=0`, and after the stall `FlushD=1`.
- $0 and saturation: `WriteRegM=0, RegWriteM=1, RsE=0` -> `ForwardAE=00`. With `STALL_CNT_W=2` and 5 stalled cycles, `stall_cycles` holds at 3.
